// File: rtl/input_buffer_port_pkg.sv
// Shared router constants and the input-buffer FSM encoding.
// Imported by the input buffer and its FIFO.
package input_buffer_port_pkg;

   localparam int TAM_FLIT_DEF     = 16;
   localparam int NPORT            = 5;
   localparam int BUFFER_DEPTH_DEF = 16;
   localparam int IB_NSTATES       = 5;
   localparam int IB_STATE_W       = $clog2(IB_NSTATES);

   typedef enum logic [IB_STATE_W-1:0] {
      IB_IDLE      = 3'd0,
      IB_REQ       = 3'd1,
      IB_SEND_HDR  = 3'd2,
      IB_SEND_SIZE = 3'd3,
      IB_PAYLOAD   = 3'd4
   } ib_state_t;

endpackage

// File: rtl/input_buffer_port_buffer_fifo.sv
// Circular flit FIFO: storage, wrapping pointers and occupancy count.
// The head flit is always presented; it is meaningless while empty.
module buffer_fifo
   import input_buffer_port_pkg::*;
#(
   parameter int WIDTH = TAM_FLIT_DEF,
   parameter int DEPTH = BUFFER_DEPTH_DEF,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Flit storage, not reset: contents are only visible through count-qualified reads.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_r] <= din;
      end
   end

   assign head  = mem[rd_ptr_r];
   assign full  = (count_r == CNT_W'(DEPTH));
   assign empty = (count_r == CNT_W'(0));
   assign count = count_r;

endmodule

// File: rtl/input_buffer_port.sv
// Router input port: credit-based receive into a FIFO, h/ack_h routing request,
// and packet streaming toward the crossbar with sender held for the whole packet.
module input_buffer_port
   import input_buffer_port_pkg::*;
#(
   parameter int TAM_FLIT     = TAM_FLIT_DEF,
   parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rx,
   input  logic [TAM_FLIT-1:0] data_in,
   output logic                credit_o,
   output logic                h,
   input  logic                ack_h,
   output logic                data_av,
   output logic [TAM_FLIT-1:0] data_out,
   input  logic                data_ack,
   output logic                sender
);

   localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

   logic                push_s;
   logic                pop_s;
   logic                full_s;
   logic                empty_s;
   logic [TAM_FLIT-1:0] head_s;
   logic [CNT_W-1:0]    count_s;

   ib_state_t           state_r;
   ib_state_t           state_next_s;
   logic                h_r;
   logic                h_next_s;
   logic                sender_r;
   logic                sender_next_s;
   logic [TAM_FLIT-1:0] remaining_r;
   logic [TAM_FLIT-1:0] remaining_next_s;
   logic                data_av_s;

   buffer_fifo #(
      .WIDTH (TAM_FLIT),
      .DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (data_in),
      .head  (head_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

   assign credit_o = !full_s;
   assign push_s   = rx & !full_s;
   assign pop_s    = data_av_s & data_ack;
   assign data_av  = data_av_s;
   assign data_out = head_s;
   assign h        = h_r;
   assign sender   = sender_r;

   // Flits are offered only while streaming a granted packet and the FIFO holds data.
   always_comb begin
      data_av_s = 1'b0;
      case (state_r)
         IB_SEND_HDR, IB_SEND_SIZE, IB_PAYLOAD: data_av_s = !empty_s;
         default:                               data_av_s = 1'b0;
      endcase
   end

   // FSM, request/sender flags and payload countdown registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IB_IDLE;
         h_r         <= 1'b0;
         sender_r    <= 1'b0;
         remaining_r <= '0;
      end else begin
         state_r     <= state_next_s;
         h_r         <= h_next_s;
         sender_r    <= sender_next_s;
         remaining_r <= remaining_next_s;
      end
   end

   // Next-state logic; leaving a packet always lands in IDLE so sender is seen low for a cycle.
   always_comb begin
      state_next_s     = state_r;
      h_next_s         = h_r;
      sender_next_s    = sender_r;
      remaining_next_s = remaining_r;
      case (state_r)
         IB_IDLE: begin
            sender_next_s = 1'b0;
            if (!empty_s) begin
               state_next_s = IB_REQ;
               h_next_s     = 1'b1;
            end else begin
               state_next_s = IB_IDLE;
               h_next_s     = 1'b0;
            end
         end
         IB_REQ: begin
            if (ack_h) begin
               state_next_s  = IB_SEND_HDR;
               h_next_s      = 1'b0;
               sender_next_s = 1'b1;
            end else begin
               state_next_s = IB_REQ;
               h_next_s     = 1'b1;
            end
         end
         IB_SEND_HDR: begin
            if (pop_s) begin
               state_next_s = IB_SEND_SIZE;
            end else begin
               state_next_s = IB_SEND_HDR;
            end
         end
         IB_SEND_SIZE: begin
            if (pop_s) begin
               remaining_next_s = head_s;
               if (head_s == TAM_FLIT'(0)) begin
                  state_next_s  = IB_IDLE;
                  sender_next_s = 1'b0;
               end else begin
                  state_next_s = IB_PAYLOAD;
               end
            end else begin
               state_next_s = IB_SEND_SIZE;
            end
         end
         IB_PAYLOAD: begin
            if (pop_s) begin
               remaining_next_s = remaining_r - TAM_FLIT'(1);
               if (remaining_r == TAM_FLIT'(1)) begin
                  state_next_s  = IB_IDLE;
                  sender_next_s = 1'b0;
               end else begin
                  state_next_s = IB_PAYLOAD;
               end
            end else begin
               state_next_s = IB_PAYLOAD;
            end
         end
         default: begin
            state_next_s     = IB_IDLE;
            h_next_s         = 1'b0;
            sender_next_s    = 1'b0;
            remaining_next_s = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_input_buffer_port.sv
// Directed bench for input_buffer_port: handshake timing, size-0 packets, full FIFO,
// back-to-back packets, stalled payload and asynchronous reset mid-packet.
module tb_input_buffer_port;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx;
   logic [15:0] data_in;
   logic        credit_o;
   logic        h;
   logic        ack_h;
   logic        data_av;
   logic [15:0] data_out;
   logic        data_ack;
   logic        sender;

   int          checks   = 0;
   int          failures = 0;
   int          pops     = 0;
   int          cmp_idx  = 0;
   logic [15:0] popq[$];
   logic [15:0] expq[$];

   input_buffer_port #(.TAM_FLIT(16), .BUFFER_DEPTH(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .rx       (rx),
      .data_in  (data_in),
      .credit_o (credit_o),
      .h        (h),
      .ack_h    (ack_h),
      .data_av  (data_av),
      .data_out (data_out),
      .data_ack (data_ack),
      .sender   (sender)
   );

   always #5 clock = ~clock;

   // Record every flit handed to the crossbar.
   always @(posedge clock) begin
      if (!reset && data_av && data_ack) begin
         pops <= pops + 1;
         popq.push_back(data_out);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_flit(input logic [15:0] d);
      rx      = 1'b1;
      data_in = d;
      expq.push_back(d);
      tick();
      rx = 1'b0;
   endtask

   task automatic grant();
      ack_h = 1'b1;
      tick();
      ack_h = 1'b0;
   endtask

   task automatic wait_h();
      for (int i = 0; i < 20 && !h; i++) tick();
      check_eq("h_wait", h, 1);
   endtask

   task automatic drain();
      data_ack = 1'b1;
      for (int i = 0; i < 40 && sender; i++) tick();
      check_eq("drain_done", sender, 0);
   endtask

   task automatic cmp_stream(input string tag);
      check_eq({tag, "_npop"}, popq.size(), expq.size());
      for (int i = cmp_idx; i < expq.size() && i < popq.size(); i++)
         check_eq({tag, "_flit"}, popq[i], expq[i]);
      cmp_idx = expq.size();
   endtask

   initial begin
      int base;
      int p;
      reset = 1'b1; rx = 1'b0; data_in = 16'h0000; ack_h = 1'b0; data_ack = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_credit", credit_o, 1);
      check_eq("rst_h", h, 0);
      check_eq("rst_data_av", data_av, 0);
      check_eq("rst_sender", sender, 0);
      reset = 1'b0;
      tick();

      // Basic packet: header, size 2, two payloads; grant 3 cycles after h.
      data_ack = 1'b1;
      push_flit(16'h0011);
      check_eq("t1_h_hdr_edge", h, 0);
      push_flit(16'h0002);
      check_eq("t1_h_next_edge", h, 1);
      push_flit(16'hAAAA);
      push_flit(16'hBBBB);
      check_eq("t1_no_pop_req", pops, 0);
      check_eq("t1_req_av", data_av, 0);
      grant();
      check_eq("t1_sender_ack", sender, 1);
      check_eq("t1_av_ack", data_av, 1);
      check_eq("t1_head", data_out, 16'h0011);
      check_eq("t1_h_drop", h, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t1_sender_mid", sender, 1);
      end
      tick();
      check_eq("t1_sender_end", sender, 0);
      check_eq("t1_pops", pops, 4);
      tick();
      check_eq("t1_sender_low", sender, 0);
      check_eq("t1_h_idle", h, 0);
      cmp_stream("t1");

      // Size-0 packet: only header and size popped.
      push_flit(16'h0022);
      push_flit(16'h0000);
      check_eq("t2_h", h, 1);
      grant();
      check_eq("t2_sender_ack", sender, 1);
      tick();
      check_eq("t2_sender_hdr", sender, 1);
      tick();
      check_eq("t2_sender_size", sender, 0);
      check_eq("t2_av_idle", data_av, 0);
      repeat (3) tick();
      check_eq("t2_pops", pops, 6);
      check_eq("t2_h_idle", h, 0);
      cmp_stream("t2");

      // Fill all 16 entries without a grant; extra rx is dropped.
      data_ack = 1'b0;
      push_flit(16'h0033);
      push_flit(16'h000E);
      for (int i = 0; i < 13; i++) push_flit(16'h0100 + 16'(i));
      check_eq("t3_credit_15", credit_o, 1);
      push_flit(16'h010D);
      check_eq("t3_credit_full", credit_o, 0);
      check_eq("t3_count_full", dut.u_fifo.count, 16);
      rx = 1'b1; data_in = 16'hDEAD;
      repeat (2) tick();
      rx = 1'b0;
      check_eq("t3_credit_ovf", credit_o, 0);
      check_eq("t3_count_ovf", dut.u_fifo.count, 16);
      check_eq("t3_h", h, 1);
      grant();
      check_eq("t3_av", data_av, 1);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check_eq("t3_credit_back", credit_o, 1);
      check_eq("t3_count_pop", dut.u_fifo.count, 15);
      drain();
      cmp_stream("t3");

      // Back-to-back size-1 packets.
      tick();
      data_ack = 1'b1;
      base = pops;
      push_flit(16'h0044); push_flit(16'h0001); push_flit(16'h4444);
      push_flit(16'h0055); push_flit(16'h0001); push_flit(16'h5555);
      wait_h();
      grant();
      repeat (3) tick();
      check_eq("t4_sender_p1", sender, 0);
      check_eq("t4_h_gap", h, 0);
      check_eq("t4_pops_p1", pops - base, 3);
      tick();
      check_eq("t4_h_p2", h, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t4_av_wait", data_av, 0);
      end
      check_eq("t4_pops_wait", pops - base, 3);
      grant();
      check_eq("t4_head_p2", data_out, 16'h0055);
      drain();
      check_eq("t4_pops_all", pops - base, 6);
      cmp_stream("t4");

      // Size-5 payload with data_ack toggling.
      tick();
      data_ack = 1'b0;
      push_flit(16'h0066);
      push_flit(16'h0005);
      for (int i = 1; i <= 5; i++) push_flit(16'h6000 + 16'(i));
      wait_h();
      grant();
      base = pops;
      p = 0;
      for (int c = 0; c < 40 && p < 7; c++) begin
         data_ack = ((c % 2) == 0);
         tick();
         p = pops - base;
         if (p >= 2) check_eq("t5_remaining", dut.remaining_r, 7 - p);
         check_eq("t5_sender", sender, (p < 7) ? 1 : 0);
      end
      check_eq("t5_pops", p, 7);
      data_ack = 1'b1;
      repeat (2) tick();
      check_eq("t5_pops_after", pops - base, 7);
      cmp_stream("t5");

      // Asynchronous reset in the middle of a payload.
      data_ack = 1'b0;
      push_flit(16'h0077);
      push_flit(16'h0003);
      push_flit(16'h7001);
      push_flit(16'h7002);
      push_flit(16'h7003);
      wait_h();
      grant();
      data_ack = 1'b1;
      repeat (3) tick();
      data_ack = 1'b0;
      check_eq("t6_sender_pre", sender, 1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_h_async", h, 0);
      check_eq("t6_sender_async", sender, 0);
      check_eq("t6_av_async", data_av, 0);
      check_eq("t6_credit_async", credit_o, 1);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) tick();
      check_eq("t6_empty", dut.u_fifo.empty, 1);
      check_eq("t6_h_after", h, 0);
      check_eq("t6_credit_after", credit_o, 1);
      while (expq.size() > cmp_idx + 3) void'(expq.pop_back());
      cmp_stream("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
